// File: rtl/cam_stream_gen_if.sv
// cam_stream_gen_if: camera pixel bus (PCLK/VSYNC/HREF/D) plus generator control and status.
interface cam_stream_gen_if;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       frame_done;
  logic       busy;
  modport master (input enable, pattern_sel, output pclk, vsync, href, d, frame_done, busy);
  modport slave (output enable, pattern_sel, input pclk, vsync, href, d, frame_done, busy);
endinterface

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: OV7670-style YCbCr 4:2:2 camera emulator producing deterministic test frames.
// Define CAM_STREAM_NOISE_EN to dither every Y byte with a 16-bit Fibonacci LFSR.
module cam_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 784,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input logic             CLOCK_24,
  input logic             rst_n,
  cam_stream_gen_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_BP   = 3'd2;
  localparam logic [2:0] S_ACT  = 3'd3;
  localparam logic [2:0] S_FP   = 3'd4;
  localparam logic [10:0] LINE_END = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] ACT_B    = 11'(2 * H_ACTIVE);
  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] BAR1     = 11'(H_ACTIVE / 4);
  localparam logic [10:0] BAR2     = 11'(H_ACTIVE / 2);
  localparam logic [10:0] BAR3     = 11'(3 * H_ACTIVE / 4);
  localparam logic [9:0]  VS_END   = 10'(V_SYNC - 1);
  localparam logic [9:0]  BP_END   = 10'(V_BP - 1);
  localparam logic [9:0]  ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  FP_END   = 10'(V_FP - 1);
  logic        pclk_q, vsync_q, href_q, frame_done_q, busy_q;
  logic [7:0]  d_q, d_d;
  logic [2:0]  state_q, state_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [9:0]  lcnt_q, lcnt_d, sq_q, sq_d, seg_end;
  logic [1:0]  pat_q, pat_d, bar;
  logic        upd, eol, eos, frame_end, start, href_d, sq_on;
  logic [10:0] xe, sq_sum;
  logic [7:0]  y_v, cb_v, cr_v, y_o;
  // Everything paced by pixel bytes moves only on the pclk 1->0 cycle.
  assign upd       = pclk_q;
  assign eol       = bcnt_q == LINE_END;
  assign seg_end   = state_q == S_SYNC ? VS_END : state_q == S_BP ? BP_END :
                     state_q == S_ACT ? ACT_END : FP_END;
  assign eos       = eol && lcnt_q == seg_end;
  assign frame_end = state_q == S_FP && eos;
  assign start     = bus.enable && (state_q == S_IDLE || frame_end);
  assign sq_sum    = {1'b0, sq_q} + 11'd4;
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    pat_d   = pat_q;
    sq_d    = upd && frame_end ? (sq_sum >= HA ? 10'(sq_sum - HA) : sq_sum[9:0]) : sq_q;
    if (upd && start) begin
      state_d = S_SYNC;
      bcnt_d  = '0;
      lcnt_d  = '0;
      pat_d   = bus.pattern_sel;
    end else if (upd && state_q != S_IDLE) begin
      bcnt_d  = eol ? '0 : bcnt_q + 11'd1;
      lcnt_d  = eos ? '0 : lcnt_q + {9'd0, eol};
      state_d = !eos ? state_q : state_q == S_SYNC ? S_BP : state_q == S_BP ? S_ACT :
                state_q == S_ACT ? S_FP : S_IDLE;
    end
  end
  // Colour is chosen per pixel pair from the even pixel x; pattern 0 Y uses each byte's own x.
  assign href_d = state_d == S_ACT && bcnt_d < ACT_B;
  assign xe     = {1'b0, bcnt_d[10:2], 1'b0};
  assign bar    = xe < BAR1 ? 2'd0 : xe < BAR2 ? 2'd1 : xe < BAR3 ? 2'd2 : 2'd3;
  assign sq_on  = pat_d == 2'd2 && lcnt_d >= 10'd208 && lcnt_d < 10'd272 &&
                  xe >= {1'b0, sq_q} && xe < {1'b0, sq_q} + 11'd64;
  assign y_v  = pat_d == 2'd0 ? bcnt_d[10:3] :
                pat_d == 2'd1 ? (bar == 2'd0 ? 8'd81 : bar == 2'd1 ? 8'd145 : bar == 2'd2 ? 8'd210 : 8'd41) :
                sq_on ? 8'd145 : 8'd16;
  assign cb_v = pat_d == 2'd1 ? (bar == 2'd0 ? 8'd90 : bar == 2'd1 ? 8'd54 : bar == 2'd2 ? 8'd16 : 8'd240) :
                sq_on ? 8'd54 : 8'd128;
  assign cr_v = pat_d == 2'd1 ? (bar == 2'd0 ? 8'd240 : bar == 2'd1 ? 8'd34 : bar == 2'd2 ? 8'd146 : 8'd110) :
                sq_on ? 8'd34 : 8'd128;
`ifdef CAM_STREAM_NOISE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge CLOCK_24 or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else if (upd && href_d && bcnt_d[0]) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign y_o = y_v ^ {6'd0, lfsr_q[1:0]};
`else
  assign y_o = y_v;
`endif
  assign d_d = !href_d ? 8'd0 : bcnt_d[0] ? y_o : bcnt_d[1] ? cr_v : cb_v;
  always_ff @(posedge CLOCK_24 or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      lcnt_q       <= '0;
      sq_q         <= '0;
      pat_q        <= '0;
    end else begin
      pclk_q       <= ~pclk_q;
      frame_done_q <= upd && frame_end;
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      lcnt_q       <= lcnt_d;
      sq_q         <= sq_d;
      pat_q        <= pat_d;
      if (upd) begin
        vsync_q <= state_d == S_SYNC;
        href_q  <= href_d;
        d_q     <= d_d;
        busy_q  <= state_d != S_IDLE;
      end
    end
  end
  assign bus.pclk       = pclk_q;
  assign bus.vsync      = vsync_q;
  assign bus.href       = href_q;
  assign bus.d          = d_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
endmodule
